// File: rtl/alu_req_ctrl_pkg.sv
// Shared opcode and FSM state types for the ALU request controller.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_EQ  = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_req_ctrl_if.sv
// Request, ALU and response bundle between the requesters/ALU/consumer and the controller.
interface alu_req_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2:0]         req_op0;
    logic [2:0]         req_op1;
    logic [WIDTH-1:0]   req_a0;
    logic [WIDTH-1:0]   req_b0;
    logic [WIDTH-1:0]   req_a1;
    logic [WIDTH-1:0]   req_b1;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_select;
    logic [2*WIDTH-1:0] alu_out;
    logic               alu_carry;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_data;
    logic               rsp_carry;
    logic               rsp_dbz;
    logic               busy;
    logic [CNT_W-1:0]   ops_done;
    logic [CNT_W-1:0]   err_count;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  alu_out, alu_carry, rsp_ready,
        output req_ready, alu_a, alu_b, alu_select,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dbz,
        output busy, ops_done, err_count
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output alu_out, alu_carry, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_select,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_dbz,
        input  busy, ops_done, err_count
    );
endinterface

// File: rtl/alu_req_ctrl_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one not served last.
module rr_arb2 (
    input  logic [1:0] req_valid_i,
    input  logic       rr_last_i,
    output logic [1:0] grant_o
);
    always_comb begin
        grant_o = req_valid_i;
        if (req_valid_i == 2'b11) begin
            grant_o = rr_last_i ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/alu_req_ctrl.sv
// Arbitrates two requesters onto a shared combinational ALU and returns results over a response channel.
module alu_req_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_req_ctrl_if.slave bus
);
    state_e               state_q, state_d;
    logic                 rr_last_q, rr_last_d;
    logic                 id_q, id_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]           sel_q, sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   data_q, data_d;
    logic                 carry_q, carry_d;
    logic                 dbz_q, dbz_d;
    logic [CNT_W-1:0]     ops_q, ops_d, err_q, err_d;
    logic [1:0]           grant;
    logic [1:0]           ready;
    logic                 dbz_now;

    rr_arb2 u_arb (
        .req_valid_i (bus.req_valid),
        .rr_last_i   (rr_last_q),
        .grant_o     (grant)
    );

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        data_d      = data_q;
        carry_d     = carry_q;
        dbz_d       = dbz_q;
        ops_d       = ops_q;
        err_d       = err_q;
        ready       = 2'b00;
        dbz_now     = 1'b0;
        case (state_q)
            IDLE: begin
                ready = grant;
                if (|(bus.req_valid & grant)) begin
                    id_d      = grant[1];
                    rr_last_d = grant[1];
                    sel_d     = grant[1] ? bus.req_op1 : bus.req_op0;
                    a_d       = grant[1] ? bus.req_a1  : bus.req_a0;
                    b_d       = grant[1] ? bus.req_b1  : bus.req_b0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // ALU operands have been stable since acceptance, so alu_out is settled here.
                dbz_now     = (sel_q == OP_DIV) && (b_q == '0);
                data_d      = dbz_now ? '0 : bus.alu_out;
                carry_d     = (sel_q == OP_ADD) && bus.alu_carry;
                dbz_d       = dbz_now;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_d       = ops_q + CNT_W'(1);
                    if (dbz_q) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ops_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            dbz_q       <= dbz_d;
            ops_q       <= ops_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_select = sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_dbz    = dbz_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.ops_done   = ops_q;
    assign bus.err_count  = err_q;
endmodule

// File: tb/tb_alu_req_ctrl.sv
// Bench for alu_req_ctrl: directed vector table, arbitration/backpressure/reset sequences, random run against a model.
module tb_alu_req_ctrl;
    localparam int W  = 4;
    localparam int CW = 4;

    typedef struct {
        int id; int op; int a; int b; int data; int carry; int dbz;
    } vec_t;

    typedef struct {
        int id; int data; int carry; int dbz;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_req_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus();

    alu_req_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int exp_ops = 0;
    int exp_err = 0;

    // Behavioural ALU; divide by zero returns all-ones so the controller's forcing to 0 is visible.
    always_comb begin
        bus.alu_out   = '0;
        bus.alu_carry = 1'b0;
        case (bus.alu_select)
            3'd0: begin
                bus.alu_out   = 8'(bus.alu_a) + 8'(bus.alu_b);
                bus.alu_carry = bus.alu_out[W];
            end
            3'd1: bus.alu_out = 8'(W'(bus.alu_a - bus.alu_b));
            3'd2: bus.alu_out = 8'(bus.alu_a & bus.alu_b);
            3'd3: bus.alu_out = 8'(bus.alu_a | bus.alu_b);
            3'd4: bus.alu_out = 8'(bus.alu_a ^ bus.alu_b);
            3'd5: bus.alu_out = 8'(bus.alu_a == bus.alu_b);
            3'd6: bus.alu_out = 8'(bus.alu_a) * 8'(bus.alu_b);
            default: bus.alu_out = (bus.alu_b == '0) ? 8'hFF : 8'(bus.alu_a / bus.alu_b);
        endcase
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic rsp_t ref_op(int id, int op, int a, int b);
        rsp_t r;
        r.id = id; r.carry = 0; r.dbz = 0; r.data = 0;
        case (op)
            0: begin r.data = a + b; r.carry = (a + b > 15) ? 1 : 0; end
            1: r.data = (a - b + 16) % 16;
            2: r.data = a & b;
            3: r.data = a | b;
            4: r.data = a ^ b;
            5: r.data = (a == b) ? 1 : 0;
            6: r.data = a * b;
            default: begin
                if (b == 0) r.dbz = 1;
                else        r.data = a / b;
            end
        endcase
        return r;
    endfunction

    task automatic set_req(int id, int op, int a, int b);
        if (id == 0) begin
            bus.req_op0 = 3'(op); bus.req_a0 = W'(a); bus.req_b0 = W'(b);
        end else begin
            bus.req_op1 = 3'(op); bus.req_a1 = W'(a); bus.req_b1 = W'(b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        #1;
        chk("rst_busy",  bus.busy, 0);
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_data",  bus.rsp_data, 0);
        chk("rst_id",    bus.rsp_id, 0);
        chk("rst_flags", {bus.rsp_carry, bus.rsp_dbz}, 0);
        chk("rst_alu",   {bus.alu_a, bus.alu_b, bus.alu_select}, 0);
        chk("rst_cnt",   {bus.ops_done, bus.err_count}, 0);
        chk("rst_ready", bus.req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ops = 0;
        exp_err = 0;
    endtask

    task automatic do_op(vec_t v);
        @(negedge clk);
        set_req(v.id, v.op, v.a, v.b);
        bus.req_valid = 2'b01 << v.id;
        bus.rsp_ready = 1'b1;
        #1;
        chk("op_ready", bus.req_ready, 2'b01 << v.id);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("op_exec_busy",  bus.busy, 1);
        chk("op_exec_valid", bus.rsp_valid, 0);
        chk("op_alu_in",     {bus.alu_select, bus.alu_a, bus.alu_b}, {3'(v.op), W'(v.a), W'(v.b)});
        @(negedge clk);
        chk("op_rsp_valid", bus.rsp_valid, 1);
        chk("op_rsp_id",    bus.rsp_id, v.id);
        chk("op_rsp_data",  bus.rsp_data, v.data);
        chk("op_rsp_flags", {bus.rsp_carry, bus.rsp_dbz}, {v.carry[0], v.dbz[0]});
        @(negedge clk);
        exp_ops++;
        if (v.dbz != 0) exp_err++;
        chk("op_done_valid", bus.rsp_valid, 0);
        chk("op_ops_done",   bus.ops_done, exp_ops % (1 << CW));
        chk("op_err_count",  bus.err_count, exp_err % (1 << CW));
        chk("op_data_hold",  bus.rsp_data, v.data);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[13];
        bit    pend[2];
        int    pop[2], pa[2], pb[2];
        rsp_t  q[$];
        rsp_t  r;
        int    ph, m_last, g;
        logic [1:0] exp_rdy;
        logic  seen;

        vecs[0]  = '{0, 0,  9,  8, 8'h11, 1, 0};
        vecs[1]  = '{1, 7,  7,  0, 8'h00, 0, 1};
        vecs[2]  = '{1, 7,  7,  2, 8'h03, 0, 0};
        vecs[3]  = '{0, 1,  3,  5, 8'h0E, 0, 0};
        vecs[4]  = '{1, 2, 12, 10, 8'h08, 0, 0};
        vecs[5]  = '{0, 3,  5, 10, 8'h0F, 0, 0};
        vecs[6]  = '{1, 4, 15,  9, 8'h06, 0, 0};
        vecs[7]  = '{0, 5,  6,  6, 8'h01, 0, 0};
        vecs[8]  = '{1, 5,  6,  7, 8'h00, 0, 0};
        vecs[9]  = '{0, 6, 15, 15, 8'hE1, 0, 0};
        vecs[10] = '{1, 0,  7,  8, 8'h0F, 0, 0};
        vecs[11] = '{0, 0, 15, 15, 8'h1E, 1, 0};
        vecs[12] = '{1, 7, 15,  1, 8'h0F, 0, 0};

        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        do_reset();

        // Only requester 0 valid after reset; no response appears without a request.
        @(negedge clk);
        bus.req_valid = 2'b01;
        #1;
        chk("t1_ready01", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;
        #1;
        chk("t1_no_rsp", bus.rsp_valid, 0);

        foreach (vecs[i]) do_op(vecs[i]);

        // Tie after reset goes to requester 0, then requester 1, then 0 again.
        do_reset();
        @(negedge clk);
        set_req(0, 6, 15, 15);
        set_req(1, 1, 3, 5);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t3_tie_first", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = 2'b10;
        chk("t3_exec_novalid", bus.rsp_valid, 0);
        @(negedge clk);
        chk("t3_rsp0", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, 1'b0, 8'hE1});
        chk("t3_ready_resp", bus.req_ready, 2'b00);
        @(negedge clk);
        chk("t3_grant1", bus.req_ready, 2'b10);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("t3_rsp1", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_carry}, {1'b1, 1'b1, 8'h0E, 1'b0});
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        chk("t3_tie_again", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("t3_rsp2", {bus.rsp_id, bus.rsp_data}, {1'b0, 8'hE1});
        @(negedge clk);
        chk("t3_ops", bus.ops_done, 3);

        // Backpressure with both requesters waiting; last served was 0, so 1 wins.
        set_req(0, 2, 12, 10);
        set_req(1, 3, 5, 10);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b0;
        #1;
        chk("t5_grant1", bus.req_ready, 2'b10);
        @(negedge clk);
        chk("t5_exec", {bus.busy, bus.req_ready}, {1'b1, 2'b00});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, 1'b1, 8'h0F});
            chk("t5_hold_ctl", {bus.req_ready, bus.busy}, {2'b00, 1'b1});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_next_grant", bus.req_ready, 2'b01);
        chk("t5_ops", bus.ops_done, 4);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("t5_rsp0", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, 1'b0, 8'h08});
        @(negedge clk);
        chk("t5_ops2", bus.ops_done, 5);

        // Asynchronous reset while EXEC discards the operation.
        set_req(0, 0, 9, 8);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("t6_in_exec", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async", {bus.busy, bus.rsp_valid, bus.ops_done, bus.err_count, bus.alu_a}, 0);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("t6_no_stale", seen, 0);

        // Random traffic against the transaction-level model.
        do_reset();
        pend[0] = 0; pend[1] = 0;
        ph = 0; m_last = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            chk("r_busy",  bus.busy, (ph != 0) ? 1 : 0);
            chk("r_valid", bus.rsp_valid, (ph == 2) ? 1 : 0);
            if (ph == 2) begin
                chk("r_id",    bus.rsp_id, q[0].id);
                chk("r_data",  bus.rsp_data, q[0].data);
                chk("r_flags", {bus.rsp_carry, bus.rsp_dbz}, {q[0].carry[0], q[0].dbz[0]});
            end
            chk("r_ops", bus.ops_done, exp_ops % (1 << CW));
            chk("r_err", bus.err_count, exp_err % (1 << CW));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    pop[i]  = $urandom_range(0, 7);
                    pa[i]   = $urandom_range(0, 15);
                    pb[i]   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
                    set_req(i, pop[i], pa[i], pb[i]);
                end
            end
            bus.req_valid = {pend[1], pend[0]};
            #1;
            exp_rdy = 2'b00;
            g = 0;
            if (ph == 0 && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) g = (m_last == 1) ? 0 : 1;
                else                    g = pend[1] ? 1 : 0;
                exp_rdy = 2'b01 << g;
            end
            chk("r_ready", bus.req_ready, exp_rdy);
            if (exp_rdy != 2'b00) begin
                r = ref_op(g, pop[g], pa[g], pb[g]);
                q.push_back(r);
                pend[g] = 0;
                m_last  = g;
                ph      = 1;
            end else if (ph == 1) begin
                ph = 2;
            end else if (ph == 2 && bus.rsp_ready) begin
                r = q.pop_front();
                exp_ops++;
                if (r.dbz != 0) exp_err++;
                ph = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
